// File: rtl/i2c_slave.sv
// Single-address I2C target: START/STOP decode, 7-bit address match, byte RX/TX with ACK handling.
// Define I2C_SLAVE_FILTER_EN to add a 3-sample glitch filter behind each input synchronizer.
module i2c_slave #(
  parameter logic [6:0] ADDRESS = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] tx_data,
  input  logic       ack_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       addressed,
  output logic       rw,
  output logic       stop_tick
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK
  } state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [7:0]  shreg, shreg_d;
  logic        nack, nack_d;
  logic        sda_low, sda_low_d;
  logic        addressed_d, rw_d, rx_valid_d, tx_req_d, stop_tick_d;
  logic [7:0]  rx_data_d;

  logic [1:0]  scl_sync, sda_sync;
  logic        scl_s, sda_s, scl_prev, sda_prev;
  logic        scl_rise, scl_fall, sda_rise, sda_fall, start, stop;

  assign SDA = sda_low ? 1'b0 : 1'bz;

  // Synchronizers reset to the idle-bus level so no false edge appears after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
    end
  end

`ifdef I2C_SLAVE_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  logic       scl_hold, sda_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_hold <= 1'b1;
      sda_hold <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_hold <= scl_s;
      sda_hold <= sda_s;
    end
  end

  // Filtered level follows the synchronizer only once three consecutive samples agree
  always_comb begin
    scl_s = scl_hold;
    sda_s = sda_hold;
    if (scl_sync[1] == scl_hist[0] && scl_hist[0] == scl_hist[1]) scl_s = scl_sync[1];
    if (sda_sync[1] == sda_hist[0] && sda_hist[0] == sda_hist[1]) sda_s = sda_sync[1];
  end
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_prev;
  assign scl_fall = ~scl_s & scl_prev;
  assign sda_rise = sda_s & ~sda_prev;
  assign sda_fall = ~sda_s & sda_prev;
  assign start    = sda_fall & scl_s;
  assign stop     = sda_rise & scl_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      nack      <= 1'b0;
      sda_low   <= 1'b0;
      addressed <= 1'b0;
      rw        <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      stop_tick <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      shreg     <= shreg_d;
      nack      <= nack_d;
      sda_low   <= sda_low_d;
      addressed <= addressed_d;
      rw        <= rw_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      tx_req    <= tx_req_d;
      stop_tick <= stop_tick_d;
    end
  end

  // Bus conditions override any data edge seen in the same cycle
  always_comb begin
    state_d = state;
    if (start) begin
      state_d = ADDR;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:     state_d = IDLE;
        ADDR:     if (scl_fall && cnt == 4'd8)
                    state_d = (shreg[7:1] == ADDRESS) ? ADDR_ACK : IDLE;
        ADDR_ACK: if (scl_fall) state_d = rw ? TX : RX;
        RX:       if (scl_fall && cnt == 4'd8) state_d = RX_ACK;
        RX_ACK:   if (scl_fall) state_d = RX;
        TX:       if (scl_fall && cnt == 4'd7) state_d = TX_ACK;
        TX_ACK:   if (scl_fall && cnt == 4'd1) state_d = nack ? IDLE : TX;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt;
    shreg_d     = shreg;
    nack_d      = nack;
    sda_low_d   = sda_low;
    addressed_d = addressed;
    rw_d        = rw;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    stop_tick_d = 1'b0;
    if (start) begin
      sda_low_d   = 1'b0;
      addressed_d = 1'b0;
    end else if (stop) begin
      sda_low_d   = 1'b0;
      addressed_d = 1'b0;
      stop_tick_d = addressed;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shreg_d = {shreg[6:0], sda_s};
            cnt_d   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8 && shreg[7:1] == ADDRESS) begin
            rw_d        = shreg[0];
            addressed_d = 1'b1;
            sda_low_d   = 1'b1;
            tx_req_d    = shreg[0];
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              shreg_d   = tx_data;
              sda_low_d = ~tx_data[7];
            end else begin
              sda_low_d = 1'b0;
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            shreg_d = {shreg[6:0], sda_s};
            cnt_d   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            rx_data_d  = shreg;
            rx_valid_d = 1'b1;
            sda_low_d  = ack_in;
          end
        end
        RX_ACK: if (scl_fall) sda_low_d = 1'b0;
        // Each fall ends the current bit; the 8th fall hands SDA to the master for its ACK
        TX: begin
          if (scl_fall) begin
            cnt_d     = cnt + 4'd1;
            shreg_d   = {shreg[6:0], 1'b0};
            sda_low_d = (cnt == 4'd7) ? 1'b0 : ~shreg[6];
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            nack_d   = sda_s;
            cnt_d    = 4'd1;
            tx_req_d = ~sda_s;
          end else if (scl_fall && cnt == 4'd1) begin
            if (nack) begin
              addressed_d = 1'b0;
            end else begin
              shreg_d   = tx_data;
              sda_low_d = ~tx_data[7];
            end
          end
        end
        default: sda_low_d = 1'b0;
      endcase
    end
    if (start || state_d != state) cnt_d = '0;
  end

endmodule
